// File: rtl/topazo_halt_reporter.sv
//------------------------------------------------------------------------------
// Module   : topazo_halt_reporter
// Brief    : Counts cycles to CPU halt, then sends cycle count, PC and ACC
//            as a 7-byte 8N1 UART packet.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module topazo_halt_reporter #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_halt,
   input  logic [10:0] i_pc,
   input  logic [15:0] i_acc,
   output logic        o_tx,
   output logic        o_busy,
   output logic        o_done
);

   localparam int c_baud_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(CLKS_PER_BIT - 1);
   localparam logic [c_baud_w-1:0] c_baud_one  = c_baud_w'(1);

   localparam logic [2:0] c_st_idle  = 3'd0;
   localparam logic [2:0] c_st_start = 3'd1;
   localparam logic [2:0] c_st_data  = 3'd2;
   localparam logic [2:0] c_st_stop  = 3'd3;
   localparam logic [2:0] c_st_done  = 3'd4;

   logic [2:0]          r_state;
   logic [15:0]         r_cyc;
   logic [10:0]         r_pc;
   logic [15:0]         r_acc;
   logic [2:0]          r_byte_idx;
   logic [2:0]          r_bit_idx;
   logic [c_baud_w-1:0] r_baud;
   logic                r_tx;
   logic                r_busy;
   logic                r_done;

   logic [7:0]          w_byte;
   logic [2:0]          w_next_bit;
   logic                w_baud_end;

   assign w_next_bit = r_bit_idx + 3'd1;
   assign w_baud_end = (r_baud == c_baud_last);

   always_comb begin
      w_byte = 8'hA5;
      case (r_byte_idx)
         3'd1:    w_byte = r_cyc[15:8];
         3'd2:    w_byte = r_cyc[7:0];
         3'd3:    w_byte = {5'b0, r_pc[10:8]};
         3'd4:    w_byte = r_pc[7:0];
         3'd5:    w_byte = r_acc[15:8];
         3'd6:    w_byte = r_acc[7:0];
         default: w_byte = 8'hA5;
      endcase
   end

   // r_cyc only advances in IDLE, so it doubles as the captured cycle count.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_state    <= c_st_idle;
         r_cyc      <= 16'd0;
         r_pc       <= 11'd0;
         r_acc      <= 16'd0;
         r_byte_idx <= 3'd0;
         r_bit_idx  <= 3'd0;
         r_baud     <= '0;
         r_tx       <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         case (r_state)
            c_st_idle: begin
               if (i_halt) begin
                  r_pc       <= i_pc;
                  r_acc      <= i_acc;
                  r_byte_idx <= 3'd0;
                  r_baud     <= '0;
                  r_tx       <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= c_st_start;
               end else if (r_cyc != 16'hFFFF) begin
                  r_cyc <= r_cyc + 16'd1;
               end
            end
            c_st_start: begin
               if (w_baud_end) begin
                  r_baud    <= '0;
                  r_bit_idx <= 3'd0;
                  r_tx      <= w_byte[0];
                  r_state   <= c_st_data;
               end else begin
                  r_baud <= r_baud + c_baud_one;
               end
            end
            c_st_data: begin
               if (w_baud_end) begin
                  r_baud <= '0;
                  if (r_bit_idx == 3'd7) begin
                     r_tx    <= 1'b1;
                     r_state <= c_st_stop;
                  end else begin
                     r_bit_idx <= w_next_bit;
                     r_tx      <= w_byte[w_next_bit];
                  end
               end else begin
                  r_baud <= r_baud + c_baud_one;
               end
            end
            c_st_stop: begin
               if (w_baud_end) begin
                  r_baud <= '0;
                  if (r_byte_idx < 3'd6) begin
                     r_byte_idx <= r_byte_idx + 3'd1;
                     r_tx       <= 1'b0;
                     r_state    <= c_st_start;
                  end else begin
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= c_st_done;
                  end
               end else begin
                  r_baud <= r_baud + c_baud_one;
               end
            end
            c_st_done: begin
               r_tx   <= 1'b1;
               r_busy <= 1'b0;
               r_done <= 1'b1;
            end
            default: begin
               r_state <= c_st_idle;
               r_tx    <= 1'b1;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_tx   = r_tx;
   assign o_busy = r_busy;
   assign o_done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_topazo_halt_reporter.sv
//------------------------------------------------------------------------------
// Module   : tb_topazo_halt_reporter
// Brief    : Randomized bench comparing the UART waveform with a packet model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_topazo_halt_reporter;

   localparam int CPB = 4;
   localparam int PKT = 70 * CPB;

   logic        clk = 1'b0;
   logic        reset;
   logic        halt;
   logic [10:0] pc;
   logic [15:0] acc;
   logic        tx;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_bytes [7];

   topazo_halt_reporter #(.CLKS_PER_BIT(CPB)) dut (
      .i_clk   (clk),
      .i_reset (reset),
      .i_halt  (halt),
      .i_pc    (pc),
      .i_acc   (acc),
      .o_tx    (tx),
      .o_busy  (busy),
      .o_done  (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_tx"},   32'(tx),   32'd1);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
   endtask

   // Line level t cycles after capture: 10 bit slots per byte (start, 8 data, stop).
   function automatic logic exp_tx(input int t);
      int slot, b, p;
      slot = t / CPB;
      b    = slot / 10;
      p    = slot % 10;
      if (p == 0) return 1'b0;
      if (p == 9) return 1'b1;
      return exp_bytes[b][p-1];
   endfunction

   task automatic run_packet(input int delay, input logic [10:0] cpc, input logic [15:0] cacc,
                             input bit noise, input int abort_at);
      logic [15:0] cyc;
      reset = 1'b0;
      halt  = 1'($urandom);
      tick();
      check_idle("rst");
      tick();
      check_idle("rst");
      reset = 1'b1;
      for (int i = 0; i < delay; i++) begin
         halt = 1'b0;
         pc   = 11'($urandom);
         acc  = 16'($urandom);
         tick();
         check_idle("pre");
      end
      cyc = (delay > 65535) ? 16'hFFFF : 16'(delay);
      exp_bytes[0] = 8'hA5;
      exp_bytes[1] = cyc[15:8];
      exp_bytes[2] = cyc[7:0];
      exp_bytes[3] = {5'b0, cpc[10:8]};
      exp_bytes[4] = cpc[7:0];
      exp_bytes[5] = cacc[15:8];
      exp_bytes[6] = cacc[7:0];
      halt = 1'b1;
      pc   = cpc;
      acc  = cacc;
      tick();
      for (int t = 0; t < PKT + 8; t++) begin
         if (t < PKT) begin
            check("tx",   32'(tx),   32'(exp_tx(t)));
            check("busy", 32'(busy), 32'd1);
            check("done", 32'(done), 32'd0);
         end else begin
            check("end_tx",   32'(tx),   32'd1);
            check("end_busy", 32'(busy), 32'd0);
            check("end_done", 32'(done), 32'd1);
         end
         halt = noise ? 1'($urandom) : 1'b0;
         if (noise) begin
            pc  = 11'($urandom);
            acc = 16'($urandom);
         end
         if (t == abort_at) reset = 1'b0;
         tick();
         if (t == abort_at) begin
            check_idle("abort");
            return;
         end
      end
   endtask

   initial begin
      reset = 1'b0;
      halt  = 1'b0;
      pc    = 11'd0;
      acc   = 16'd0;
      tick();
      check_idle("por");

      run_packet(10, 11'h123, 16'hBEEF, 1'b0, -1);
      run_packet(0, 11'h7FF, 16'h0000, 1'b0, -1);
      run_packet(3, 11'($urandom), 16'($urandom), 1'b1, -1);
      run_packet(int'($urandom_range(1, 30)), 11'($urandom), 16'($urandom), 1'b0, CPB * 33 + 1);
      run_packet(5, 11'($urandom), 16'($urandom), 1'b0, -1);
      for (int r = 0; r < 4; r++)
         run_packet(int'($urandom_range(0, 200)), 11'($urandom), 16'($urandom),
                    1'($urandom), -1);
      run_packet(70000, 11'($urandom), 16'($urandom), 1'b0, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/topazo_halt_reporter.md
# topazo_halt_reporter

Serial reporter that observes the TOPAZO CPU from outside and transmits its final state over a UART line. It counts clock cycles from reset release until the CPU asserts halt, then captures the PC and accumulator. It sends a fixed 7-byte packet (8N1, LSB first) so the host or bench can read back the program result. It sits beside `TOPAZO_cpu` at top level, shares its clock and reset, and only reads CPU outputs.

## Interface
- `CLKS_PER_BIT`, 16, clock cycles per UART bit; legal values are ≥2.
- `i_clk`  in  1  system clock, rising-edge.
- `i_reset`  in  1  reset; synchronous, active-low (0 = reset).
- `i_halt`  in  1  CPU halt indication, level.
- `i_pc`  in  11  CPU program counter.
- `i_acc`  in  16  CPU accumulator.
- `o_tx`  out  1  UART serial line; idles high.
- `o_busy`  out  1  high while a packet is being transmitted.
- `o_done`  out  1  high after the packet is complete; sticky until reset.

## Operation
- The reset value of every output is `o_tx=1`, `o_busy=0`, `o_done=0`. Reset also clears all counters and the captured registers, and sets the FSM to IDLE.
- The cycle counter CYC is 16 bits and is 0 after reset.
  - In IDLE, when `i_halt` is 0, CYC increments by 1 per clock.
  - CYC saturates at 0xFFFF and does not wrap.
- Capture happens on the first clock edge in IDLE where `i_halt` = 1.
  - It latches CYC (the value before that edge's increment), `i_pc` and `i_acc`.
  - The FSM then moves to START with byte index 0.
- The packet is sent in this byte order:
  - 0xA5 (header)
  - CYC[15:8], CYC[7:0]
  - {5'b0, PC[10:8]}, PC[7:0]
  - ACC[15:8], ACC[7:0]
- FSM states and transitions:
  - IDLE → START on halt capture.
  - START drives `o_tx=0` → DATA.
  - DATA sends bits 0..7, LSB first → STOP.
  - STOP drives `o_tx=1`. If the byte index is less than 6, increment it and go to START; otherwise go to DONE.
  - DONE holds `o_tx=1` and `o_done=1`, and stays there until reset.
- Each of START, each DATA bit, and STOP lasts exactly `CLKS_PER_BIT` clocks, timed by the baud counter. The baud counter is `$clog2(CLKS_PER_BIT)` bits wide and counts from 0 to CLKS_PER_BIT−1.
- There is no idle gap between bytes: the STOP bit is followed directly by the next START.
- `o_busy` = 1 in START, DATA and STOP; it is 0 in IDLE and DONE.
- `i_halt` is ignored outside IDLE. This covers deassertion during transmission and any re-assertion after DONE.
- `i_pc` and `i_acc` are sampled only at capture. Later changes do not affect the packet.
- All outputs are registered; no output is driven combinationally from an input.

## Timing
- Latency: let capture happen at edge N. Then `o_tx` falls and `o_busy` rises at edge N (both registered from capture).
- The start bit of byte 0 occupies cycles N..N+CLKS_PER_BIT−1.
- Bit k of byte b starts at edge N + (10·b + 1 + k)·CLKS_PER_BIT.
- The packet length is 70·CLKS_PER_BIT clocks.
- At edge N + 70·CLKS_PER_BIT: `o_busy` goes to 0 and `o_done` goes to 1 on the same edge.
- CYC semantics: if `i_halt` = 1 on the first edge after `i_reset` goes high, CYC = 0. If halt is first seen k edges after reset release, CYC = k (capped at 0xFFFF).
- Reset mid-packet: `i_reset` = 0 sampled at any edge gives `o_tx=1`, `o_busy=0`, `o_done=0` at that edge. The partial byte is abandoned and no packet is resumed.
- A 1-cycle `i_halt` pulse in IDLE is sufficient to trigger capture.

## Test plan
All scenarios use CLKS_PER_BIT = 4.
- **Basic packet:** release reset; 10 edges later assert `i_halt` with `i_pc=0x123`, `i_acc=0xBEEF`.
  - Decoded bytes are A5 00 0A 01 23 BE EF.
  - Each bit is 4 cycles wide.
  - `o_busy` stays high for exactly 280 cycles, then `o_done`=1 and `o_tx`=1.
- **Immediate halt:** `i_halt`=1 already at the first edge after reset release, with PC=0x7FF and ACC=0x0000.
  - Bytes are A5 00 00 07 FF 00 00.
  - The start bit appears on that same edge.
- **Input stability:** give a 1-cycle halt pulse, then change `i_pc`/`i_acc` and toggle `i_halt` during transmission.
  - The packet carries the values captured at the pulse.
  - After DONE, a new `i_halt` produces no further activity on `o_tx`.
- **Reset mid-packet:** assert `i_reset`=0 during DATA of byte 3.
  - `o_tx`=1, `o_busy`=0 and `o_done`=0 from that edge.
  - After release plus a halt 5 edges later, a fresh packet is sent with CYC=0x0005.
- **Saturation:** hold `i_halt`=0 for 70000 cycles after reset, then assert it.
  - The CYC bytes are FF FF.
  - The rest of the packet is correct.
